seven_segment_scan_ctrl: RTL

//  Time-multiplexes DIGITS BCD digits onto one shared seven_segment decoder.

---
 rtl/seven_segment_scan_ctrl_if.sv | 22 ++
 rtl/seven_segment_scan_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/seven_segment_scan_ctrl_if.sv
// Bus between the display register logic (master) and the scan controller (slave).
interface seven_segment_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  load_i;
    logic [4*DIGITS-1:0]   value_i;
    logic                  pending_o;
    logic [3:0]            num_o;
    logic [DIGITS-1:0]     digit_en_o;
    logic                  frame_o;
    logic                  bcd_err_o;

    modport master (
        output load_i, value_i,
        input  pending_o, num_o, digit_en_o, frame_o, bcd_err_o
    );

    modport slave (
        input  load_i, value_i,
        output pending_o, num_o, digit_en_o, frame_o, bcd_err_o
    );
endinterface

// File: rtl/seven_segment_scan_ctrl.sv
// Time-multiplexed BCD digit scanner with frame-synchronous double buffering.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seven_segment_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    seven_segment_scan_ctrl_if.slave bus
);
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_V = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    function automatic logic bcd_valid(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic                pending_q, pending_d;
    logic                err_q, err_d;

    logic                frame_end_s;
    logic [3:0]          num_s;
    logic [DIGITS-1:0]   onehot_s;
    logic [DIGITS-1:0]   en_s;
    logic                lz_hide_s;

    assign frame_end_s = (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);
    assign num_s       = disp_q[{idx_q, 2'b00} +: 4];
    assign onehot_s    = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;

`ifdef LEADING_ZERO_BLANK_EN
    // Hide digit idx when it and every more-significant digit are zero; digit 0 never hides.
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        lz_hide_s = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run  = zero_run & (disp_q[4*i +: 4] == 4'd0);
            lz_hide_s = (idx_q == IDX_W'(i)) ? zero_run : lz_hide_s;
        end
    end
`else
    assign lz_hide_s = 1'b0;
`endif

    // Digit enable: blank window at slot start, invalid codes and hidden zeros stay dark.
    always_comb begin
        if ((cnt_q >= BLANK_V) && bcd_valid(num_s) && !lz_hide_s) begin
            en_s = onehot_s;
        end else begin
            en_s = '0;
        end
    end

    // Next-state: scan counters, buffer transfer and sticky error.
    always_comb begin
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end

        disp_d    = disp_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        // A load landing on the frame-end cycle bypasses the shadow and wins over it.
        if (bus.load_i && frame_end_s) begin
            disp_d    = bus.value_i;
            pending_d = 1'b0;
        end else if (bus.load_i) begin
            shadow_d  = bus.value_i;
            pending_d = 1'b1;
        end else if (frame_end_s && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        err_d = err_q | ~bcd_valid(num_s);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            disp_q    <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign bus.pending_o  = pending_q;
    assign bus.num_o      = num_s;
    assign bus.digit_en_o = en_s;
    assign bus.frame_o    = frame_end_s;
    assign bus.bcd_err_o  = err_q;
endmodule
